lut_sweep_checker: RTL and testbench
====================================

Name: lut_sweep_checker

Overview:
- Sequential stimulus/check stage that sits directly upstream of a combinational LUT (and2/and4/equation style).
- Drives every LUT address in order and samples the LUT result after a settle window.
- Compares each sample against a parameterised truth-table mask, counts mismatches and reports pass/fail.
- Provides an in-fabric, self-checking replacement for the delay-driven bench loop around LUT blocks.

Parameters:
- ADDR_W, 4, LUT address width; the sweep covers 2^ADDR_W addresses. Legal range 1..8.
- SETTLE_CYCLES, 2, cycles each address is held before sampling. Must be at least 1.
- EXPECT_MASK, 16'h8000, expected truth table, 2^ADDR_W bits; bit i is the expected result at address i. The default is the 4-input AND.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; sampled in IDLE or DONE only
- lut_result  in  1  result from the LUT under check
- lut_address  out  ADDR_W  address driven to the LUT
- busy  out  1  high while sweeping
- done  out  1  level; high in DONE until the next start or reset
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  ADDR_W+1  number of mismatching addresses; saturation is not needed because the width holds 2^ADDR_W
- first_fail_addr  out  ADDR_W  lowest failing address; 0 if none
- fail_seen  out  1  at least one mismatch recorded in the current sweep

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All outputs are registered.
- Reset values: lut_address=0, busy=0, done=0, pass=0, err_count=0, first_fail_addr=0, fail_seen=0, state=IDLE, settle counter=0.
- States: IDLE, SETTLE, DONE.
- IDLE, on start=1 at edge t:
  - enter SETTLE; lut_address=0; settle counter=0.
  - clear err_count, first_fail_addr, fail_seen and pass.
  - busy=1 from t+1.
- SETTLE, each edge:
  - If counter < SETTLE_CYCLES-1: increment the counter.
  - If counter == SETTLE_CYCLES-1: compare lut_result with EXPECT_MASK[lut_address]. On mismatch, increment err_count. If fail_seen=0 at that edge, also load first_fail_addr=lut_address and set fail_seen=1.
  - Then, if lut_address == 2^ADDR_W-1: go to DONE. Otherwise increment lut_address and reset the counter to 0.
- No wrap: the address never returns to 0 within a sweep. lut_address holds the last address in DONE and returns to 0 only on a new start or reset.
- DONE: busy=0, done=1, pass=(err_count==0). The final compare is included in pass. Start in DONE behaves exactly as start in IDLE, restarting with cleared counters.
- Timing: a sweep occupies 2^ADDR_W × SETTLE_CYCLES cycles with busy=1. With defaults, start sampled at edge t gives busy high for cycles t+1..t+32 and done=1 from t+33.
- start while busy=1 is ignored and has no effect on the sweep.
- rst=1 at any edge, including mid-sweep or simultaneous with start: return to reset values. Reset wins over start.
- lut_result is sampled only on compare edges; its value at other cycles is irrelevant.

Optional Feature:
- Macro: LUT_SWEEP_STOP_ON_FAIL_EN.
- Defined: at the first mismatch, after err_count=1, first_fail_addr and fail_seen are recorded, go directly to DONE. lut_address holds the failing address, pass=0 and err_count stays 1.
- Undefined: the sweep always covers every address and counts all mismatches.

Test Plan:
1. Defaults; correct AND4 model on lut_result; pulse start -> busy high exactly 32 cycles; done=1, pass=1, err_count=0, fail_seen=0, lut_address=15.
2. LUT stuck-at-0 -> done; pass=0, err_count=1, first_fail_addr=15, fail_seen=1.
3. LUT stuck-at-1 -> err_count=15, first_fail_addr=0. With LUT_SWEEP_STOP_ON_FAIL_EN defined -> done after 2 busy cycles, err_count=1, lut_address=0.
4. Pulse start again at address 5 mid-sweep -> ignored; sweep still ends at t+33 with the same results as scenario 1.
5. Assert rst while lut_address=7 -> next cycle all outputs at reset values, state IDLE. A following start runs a full 32-cycle sweep.
6. ADDR_W=2, EXPECT_MASK=4'h8, SETTLE_CYCLES=1, LUT inverted -> busy 4 cycles; err_count=4, first_fail_addr=0. Then restart from DONE with a correct LUT -> err_count cleared, pass=1.

Source files
------------

// File: rtl/lut_sweep_checker.sv
// Sweeps every LUT address, samples the result after a settle window and checks it against EXPECT_MASK.
// Optional: define LUT_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module lut_sweep_checker #(
    parameter int unsigned          ADDR_W        = 4,
    parameter int unsigned          SETTLE_CYCLES = 2,
    parameter logic [2**ADDR_W-1:0] EXPECT_MASK   = 16'h8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              lut_result,
    output logic [ADDR_W-1:0] lut_address,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              fail_seen
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0]   CntLast  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic              fail_seen_q, fail_seen_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mismatch;
    logic              sweep_end;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_d       = err_q;
        ffa_d       = ffa_q;
        fail_seen_d = fail_seen_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        done_d      = done_q;
        mismatch    = 1'b0;
        sweep_end   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StSettle;
                    cnt_d       = '0;
                    addr_d      = '0;
                    err_d       = '0;
                    ffa_d       = '0;
                    fail_seen_d = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    mismatch = (lut_result != EXPECT_MASK[addr_q]);
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_seen_q) begin
                            ffa_d       = addr_q;
                            fail_seen_d = 1'b1;
                        end
                    end
`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
                    sweep_end = mismatch || (addr_q == AddrLast);
`else
                    sweep_end = (addr_q == AddrLast);
`endif
                    if (sweep_end) begin
                        // Address is held so the final (or failing) address stays visible.
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            err_q       <= '0;
            ffa_q       <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            ffa_q       <= ffa_d;
            fail_seen_q <= fail_seen_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lut_address     = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_addr = ffa_q;
    assign fail_seen       = fail_seen_q;

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Randomized bench for lut_sweep_checker: two instances (4-bit/2-cycle AND4 and 2-bit/1-cycle AND2)
// checked against a truth-table reference model.
module tb_lut_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [15:0] tbl_a;
    logic [3:0]  tbl_b;
    logic        lut_a, lut_b;

    logic [3:0] addr_a, ffa_a;
    logic [4:0] err_a;
    logic       busy_a, done_a, pass_a, fs_a;
    logic [1:0] addr_b, ffa_b;
    logic [2:0] err_b;
    logic       busy_b, done_b, pass_b, fs_b;

    assign lut_a = tbl_a[addr_a];
    assign lut_b = tbl_b[addr_b];

    lut_sweep_checker u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .start           (start_a),
        .lut_result      (lut_a),
        .lut_address     (addr_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_count       (err_a),
        .first_fail_addr (ffa_a),
        .fail_seen       (fs_a)
    );

    lut_sweep_checker #(
        .ADDR_W        (2),
        .SETTLE_CYCLES (1),
        .EXPECT_MASK   (4'h8)
    ) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .start           (start_b),
        .lut_result      (lut_b),
        .lut_address     (addr_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_count       (err_b),
        .first_fail_addr (ffa_b),
        .fail_seen       (fs_b)
    );

    int checks   = 0;
    int failures = 0;
    bit cur;  // 0 selects u_dut_a, 1 selects u_dut_b

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"}, int'(addr_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_pass"}, int'(pass_a), 0);
        check({tag, "_err"}, int'(err_a), 0);
        check({tag, "_ffa"}, int'(ffa_a), 0);
        check({tag, "_fs"}, int'(fs_a), 0);
    endtask

    // Runs one sweep on the selected instance and compares against the truth-table model.
    task automatic sweep(input bit sel, input logic [15:0] tbl, input bit poke);
        int n, s, exp_err, exp_ffa, exp_busy, exp_last, cycles;
        logic [15:0] mask;
        bit found, poked;
        cur  = sel;
        n    = sel ? 4 : 16;
        s    = sel ? 1 : 2;
        mask = sel ? 16'h0008 : 16'h8000;
        if (sel) tbl_b = tbl[3:0];
        else     tbl_a = tbl;

        exp_err = 0; exp_ffa = 0; found = 0;
        for (int i = 0; i < n; i++) begin
            if (tbl[i] != mask[i]) begin
                exp_err++;
                if (!found) begin
                    found   = 1;
                    exp_ffa = i;
                end
            end
        end
        exp_busy = n * s;
        exp_last = n - 1;
`ifdef LUT_SWEEP_STOP_ON_FAIL_EN
        if (found) begin
            exp_err  = 1;
            exp_busy = (exp_ffa + 1) * s;
            exp_last = exp_ffa;
        end
`endif

        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cycles  = 0;
        poked   = 0;
        while ((sel ? busy_b : busy_a) && cycles < 200) begin
            cycles++;
            if (poke && !sel && addr_a == 4'd5 && !poked) begin
                start_a = 1'b1;
                poked   = 1;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        start_a = 1'b0;

        check("busy_cycles", cycles, exp_busy);
        check("done", int'(sel ? done_b : done_a), 1);
        check("pass", int'(sel ? pass_b : pass_a), (exp_err == 0) ? 1 : 0);
        check("err_count", int'(sel ? err_b : err_a), exp_err);
        check("first_fail_addr", int'(sel ? ffa_b : ffa_a), exp_ffa);
        check("fail_seen", int'(sel ? fs_b : fs_a), found ? 1 : 0);
        check("last_addr", int'(sel ? addr_b : addr_a), exp_last);
        // DONE is a level and must hold while idle.
        repeat (3) @(negedge clk);
        check("done_hold", int'(sel ? done_b : done_a), 1);
    endtask

    function automatic logic [15:0] rand_tbl(input logic [15:0] good, input int n);
        logic [15:0] r;
        r = 16'($urandom);
        unique case ($urandom_range(0, 3))
            0: return good;
            1: return good ^ (16'h1 << $urandom_range(0, n - 1));
            2: return r;
            default: return good ^ r ^ (r << 3);
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tbl_a   = 16'h8000;
        tbl_b   = 4'h8;
        cur     = 0;
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset_b_busy", int'(busy_b), 0);
        check("reset_b_err", int'(err_b), 0);
        rst = 1'b0;

        // Directed: correct AND4, stuck-at-0, stuck-at-1, mid-sweep start ignored.
        sweep(0, 16'h8000, 0);
        sweep(0, 16'h0000, 0);
        sweep(0, 16'hffff, 0);
        sweep(0, 16'h8000, 1);

        // Reset while sweeping at address 7.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 100 && addr_a != 4'd7; i++) @(negedge clk);
        check("reached_addr7", int'(addr_a), 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_a("midreset");
        check("midreset_stay_idle", int'(busy_a), 0);
        sweep(0, 16'h8000, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst     = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        check_reset_a("rst_vs_start");

        // Small instance: inverted AND2, then restart from DONE with a correct LUT.
        sweep(1, 16'h0007, 0);
        sweep(1, 16'h0008, 0);

        for (int k = 0; k < 8; k++) begin
            sweep(0, rand_tbl(16'h8000, 16), ($urandom_range(0, 1) == 1));
            sweep(1, rand_tbl(16'h0008, 4) & 16'h000f, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
